// File: rtl/sliced_subtractor.sv
// Bit-serial/sliced 32-bit subtractor: computes a - b - bin over 32/SLICE_W cycles with a valid/ready handshake.
// Optional build macro SLICED_SUBTRACTOR_SATURATE_EN clamps diff to the signed range on overflow.
module sliced_subtractor #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] diff,
  output logic        bout,
  output logic        overflow,
  output logic        zero,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int DATA_W = 32;
  localparam int N      = DATA_W / SLICE_W;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [DATA_W-1:0] SLICE_MASK =
    (SLICE_W == DATA_W) ? {DATA_W{1'b1}} : ((DATA_W'(1) << SLICE_W) - DATA_W'(1));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

`ifdef SLICED_SUBTRACTOR_SATURATE_EN
  function automatic logic [DATA_W-1:0] sat_fn(input logic [DATA_W-1:0] raw,
                                               input logic ovf, input logic a_msb);
    logic [DATA_W-1:0] res;
    res = raw;
    if (ovf) res = a_msb ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return res;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0] diff_q, diff_d;
  logic              bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] sh;
  logic [SLICE_W-1:0] a_s, b_s;
  logic [SLICE_W:0]   sum;
  logic [DATA_W-1:0] merged, final_diff;
  logic              raw_ovf;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    // Slice datapath: a_s + ~b_s + carry, merged into the partial result
    sh      = DATA_W'(idx_q) * DATA_W'(SLICE_W);
    a_s     = SLICE_W'(a_q >> sh);
    b_s     = SLICE_W'(b_q >> sh);
    sum     = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE_W{1'b0}}, carry_q};
    merged  = (res_q & ~(SLICE_MASK << sh)) | (DATA_W'(sum[SLICE_W-1:0]) << sh);
    raw_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) & (merged[DATA_W-1] != a_q[DATA_W-1]);
`ifdef SLICED_SUBTRACTOR_SATURATE_EN
    final_diff = sat_fn(merged, raw_ovf, a_q[DATA_W-1]);
`else
    final_diff = merged;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = merged;
        carry_d = sum[SLICE_W];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          diff_d      = final_diff;
          bout_d      = ~sum[SLICE_W];
          ovf_d       = raw_ovf;
          zero_d      = (final_diff == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand and partial-result registers
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

endmodule

// File: tb/tb_sliced_subtractor.sv
// Bench for sliced_subtractor: four instances (SLICE_W = 1, 4, 8, 32) share stimulus; directed vector table plus hold/abort sequences.
module tb_sliced_subtractor;

  localparam int NI = 4;
  localparam int SWS [NI] = '{1, 4, 8, 32};

  logic        clk = 1'b0;
  logic        rst, bin, in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready_w  [NI];
  logic [31:0] diff_w      [NI];
  logic        bout_w      [NI];
  logic        ovf_w       [NI];
  logic        zero_w      [NI];
  logic        out_valid_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sliced_subtractor #(.SLICE_W(SWS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .diff      (diff_w[g]),
      .bout      (bout_w[g]),
      .overflow  (ovf_w[g]),
      .zero      (zero_w[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready)
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs [9];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_and_wait(input vec_t v);
    int lat [NI];
    @(negedge clk);
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'b1;
    for (int g = 0; g < NI; g++) lat[g] = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++)
        if (lat[g] == 0 && out_valid_w[g]) lat[g] = cyc;
    end
    for (int g = 0; g < NI; g++)
      chk($sformatf("latency sw%0d", SWS[g]), 32'(lat[g]), 32'(32 / SWS[g]));
  endtask

  task automatic check_outputs(input vec_t v, input string tag);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s diff sw%0d", tag, SWS[g]), diff_w[g], v.d);
      chk($sformatf("%s bout sw%0d", tag, SWS[g]), 32'(bout_w[g]), 32'(v.bo));
      chk($sformatf("%s ovf sw%0d", tag, SWS[g]), 32'(ovf_w[g]), 32'(v.ov));
      chk($sformatf("%s zero sw%0d", tag, SWS[g]), 32'(zero_w[g]), 32'(v.z));
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s out_valid drop sw%0d", tag, SWS[g]), 32'(out_valid_w[g]), 32'd0);
      chk($sformatf("%s in_ready rise sw%0d", tag, SWS[g]), 32'(in_ready_w[g]), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h1234_ABCD,  32'h1234_ABCD,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_ABCD,  32'h1234_ABCD,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
`ifdef SLICED_SUBTRACTOR_SATURATE_EN
    vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000,  32'h0000_0001,  1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
`else
    vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000,  32'h0000_0001,  1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
`endif
    vecs[6] = '{32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0000,  32'h0000_0000,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst in_ready sw%0d", SWS[g]), 32'(in_ready_w[g]), 32'd0);
      chk($sformatf("rst out_valid sw%0d", SWS[g]), 32'(out_valid_w[g]), 32'd0);
      chk($sformatf("rst diff sw%0d", SWS[g]), diff_w[g], 32'd0);
      chk($sformatf("rst flags sw%0d", SWS[g]),
          32'({bout_w[g], ovf_w[g], zero_w[g]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      chk($sformatf("post-rst in_ready sw%0d", SWS[g]), 32'(in_ready_w[g]), 32'd1);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      start_and_wait(vecs[i]);
      check_outputs(vecs[i], $sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Hold in DONE with out_ready low and changing operands
    start_and_wait(vecs[0]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; bin = c[0];
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("hold%0d out_valid sw%0d", c, SWS[g]), 32'(out_valid_w[g]), 32'd1);
        chk($sformatf("hold%0d in_ready sw%0d", c, SWS[g]), 32'(in_ready_w[g]), 32'd0);
      end
      check_outputs(vecs[0], $sformatf("hold%0d", c));
    end
    handshake("hold");
    start_and_wait(vecs[1]);
    check_outputs(vecs[1], "after-hold");
    handshake("after-hold");

    // Reset abort during the second CALC cycle
    @(negedge clk);
    a = vecs[4].a; b = vecs[4].b; bin = vecs[4].bin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("abort out_valid sw%0d", SWS[g]), 32'(out_valid_w[g]), 32'd0);
      chk($sformatf("abort in_ready sw%0d", SWS[g]), 32'(in_ready_w[g]), 32'd0);
      chk($sformatf("abort diff sw%0d", SWS[g]), diff_w[g], 32'd0);
      chk($sformatf("abort flags sw%0d", SWS[g]),
          32'({bout_w[g], ovf_w[g], zero_w[g]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      chk($sformatf("abort in_ready low-rst sw%0d", SWS[g]), 32'(in_ready_w[g]), 32'd1);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) if (out_valid_w[g]) seen++;
      end
      chk("abort no out_valid", 32'(seen), 32'd0);
    end
    start_and_wait(vecs[4]);
    check_outputs(vecs[4], "post-abort");
    handshake("post-abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
